// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, absorbs the one-cycle imem read
// latency and presents one instruction per cycle to decode with a
// valid/stall handshake. A one-entry skid buffer catches the word that is
// already in flight when decode stalls, so nothing is lost or duplicated.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [31:0]       q_imem,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight_valid;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_skid_valid;
  logic [31:0]       r_skid_instr;
  logic [ADDR_W-1:0] r_skid_pc;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_inflight_valid_nxt;
  logic [ADDR_W-1:0] w_inflight_pc_nxt;
  logic [31:0]       w_instr_nxt;
  logic [ADDR_W-1:0] w_instr_pc_nxt;
  logic              w_instr_valid_nxt;
  logic              w_skid_valid_nxt;
  logic [31:0]       w_skid_instr_nxt;
  logic [ADDR_W-1:0] w_skid_pc_nxt;
  logic              w_issue;
  logic              w_out_free;

  // Next-state: redirect flush, fetch issue, and routing of the arriving word
  always_comb begin
    w_pc_nxt             = r_pc;
    w_inflight_valid_nxt = r_inflight_valid;
    w_inflight_pc_nxt    = r_inflight_pc;
    w_instr_nxt          = r_instr;
    w_instr_pc_nxt       = r_instr_pc;
    w_instr_valid_nxt    = r_instr_valid;
    w_skid_valid_nxt     = r_skid_valid;
    w_skid_instr_nxt     = r_skid_instr;
    w_skid_pc_nxt        = r_skid_pc;

    // Stop fetching only when a held output already has a word queued behind it
    w_issue    = !(r_instr_valid && stall && (r_inflight_valid || r_skid_valid));
    w_out_free = !r_instr_valid || !stall;

    if (redirect) begin
      w_pc_nxt             = redirect_target;
      w_inflight_valid_nxt = 1'b0;
      w_skid_valid_nxt     = 1'b0;
      w_instr_valid_nxt    = 1'b0;
    end else begin
      if (w_issue) begin
        w_pc_nxt             = r_pc + ADDR_W'(1);
        w_inflight_valid_nxt = 1'b1;
        w_inflight_pc_nxt    = r_pc;
      end else begin
        w_inflight_valid_nxt = 1'b0;
      end

      if (r_inflight_valid) begin
        if (w_out_free) begin
          if (r_skid_valid) begin
            // Older skid word goes out first; the new word takes its place
            w_instr_nxt      = r_skid_instr;
            w_instr_pc_nxt   = r_skid_pc;
            w_skid_instr_nxt = q_imem;
            w_skid_pc_nxt    = r_inflight_pc;
          end else begin
            w_instr_nxt    = q_imem;
            w_instr_pc_nxt = r_inflight_pc;
          end
          w_instr_valid_nxt = 1'b1;
        end else begin
          w_skid_valid_nxt = 1'b1;
          w_skid_instr_nxt = q_imem;
          w_skid_pc_nxt    = r_inflight_pc;
        end
      end else if (w_out_free) begin
        if (r_skid_valid) begin
          w_instr_nxt       = r_skid_instr;
          w_instr_pc_nxt    = r_skid_pc;
          w_instr_valid_nxt = 1'b1;
          w_skid_valid_nxt  = 1'b0;
        end else begin
          w_instr_valid_nxt = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc             <= PC_INIT;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
      r_instr          <= '0;
      r_instr_pc       <= '0;
      r_instr_valid    <= 1'b0;
      r_skid_valid     <= 1'b0;
      r_skid_instr     <= '0;
      r_skid_pc        <= '0;
    end else begin
      r_pc             <= w_pc_nxt;
      r_inflight_valid <= w_inflight_valid_nxt;
      r_inflight_pc    <= w_inflight_pc_nxt;
      r_instr          <= w_instr_nxt;
      r_instr_pc       <= w_instr_pc_nxt;
      r_instr_valid    <= w_instr_valid_nxt;
      r_skid_valid     <= w_skid_valid_nxt;
      r_skid_instr     <= w_skid_instr_nxt;
      r_skid_pc        <= w_skid_pc_nxt;
    end
  end

  assign address_imem = r_pc;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign instr_valid  = r_instr_valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage between the synchronous instruction ROM (imem) and the processor core's decode logic.
- Owns the program counter and drives the imem address.
- Absorbs imem's one-cycle read latency and delivers one instruction per cycle with a valid/stall handshake.
- Supports a branch/jump redirect, which squashes in-flight fetches.

Parameters:
ADDR_W, 12, width of imem word address and PC
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
address_imem  output  ADDR_W  word address to imem; driven directly from the PC register
q_imem  input  32  imem read data; valid the cycle after the address was presented
instr  output  32  instruction delivered to core
instr_pc  output  ADDR_W  address of instr
instr_valid  output  1  instr/instr_pc hold a live instruction
stall  input  1  core cannot accept; hold outputs
redirect  input  1  one-cycle request to change PC
redirect_target  input  ADDR_W  new PC when redirect=1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values:
  - pc = RESET_PC, so address_imem = RESET_PC.
  - instr = 0, instr_pc = 0, instr_valid = 0.
  - inflight_valid = 0, inflight_pc = 0.
  - skid_valid = 0, skid_instr = 0, skid_pc = 0.
- Reset dominates redirect and stall, and takes effect mid-operation with no residue.
- Internal state:
  - pc register.
  - inflight record (valid, pc): the address imem sampled last edge.
  - Output register (instr, instr_pc, instr_valid).
  - One-entry skid buffer (skid_valid, skid_instr, skid_pc).
- Handshake: a transfer occurs on an edge where instr_valid=1 and stall=0. While instr_valid=1 and stall=1, instr and instr_pc are held bit-stable.
- Issue rule:
  - issue = !(instr_valid && stall && (inflight_valid || skid_valid)).
  - On issue: pc <= pc+1 modulo 2^ADDR_W (0xFFF wraps to 0x000), inflight_valid <= 1, inflight_pc <= pc.
  - With no issue: pc holds and inflight_valid <= 0.
- Arrival (inflight_valid=1, q_imem carries the word for inflight_pc), one case applies:
  - Output free or being consumed, skid empty: word goes to the output register.
  - Output free or being consumed, skid full: skid goes to the output register, the word goes to the skid.
  - Output held (stalled): word goes to the skid. The issue rule guarantees the skid is empty in this case.
- No arrival, output free or consumed:
  - If skid_valid: output <= skid, skid empties.
  - Otherwise: instr_valid <= 0.
- Redirect (no reset), priority over stall and issue:
  - Next edge: pc <= redirect_target, inflight_valid <= 0, skid_valid <= 0, instr_valid <= 0.
  - The word arriving the cycle after the redirect is discarded.
  - The stall value is ignored on the redirect edge.
- Latency:
  - Address presented in cycle n gives that instruction on the outputs in cycle n+2 (instr_valid=1).
  - After reset release, or a redirect asserted in cycle t: instr_valid is low in cycles t+1 and t+2, and the first instruction appears in cycle t+3.
  - Steady-state throughput is 1 instruction/cycle.
- Ordering: instructions are delivered strictly in PC order with no loss or duplication across any stall pattern.
- Storage bound: at most 3 instructions are resident (output + skid + in-flight). Overflow is impossible by construction.
- Out of scope: q_imem is not checked or decoded.

Test Plan:
(In all scenarios imem word at address a = 0xA0000000 | a.)
1. Reset release with stall=0 → address_imem 0,1,2,… on successive cycles; instr_valid first high 2 cycles later with instr=0xA0000000, instr_pc=0; then one new instruction every cycle.
2. stall=1 for 4 cycles while instr_pc=5 is valid → instr held at 0xA0000005; address_imem freezes after at most one further increment; after release, instr_pc sequence is 6,7,8,… with no gap or repeat.
3. redirect=1, redirect_target=0x100 in cycle t while streaming → instr_valid=0 in t+1 and t+2; t+3: instr=0xA0000100, instr_pc=0x100; the word fetched in cycle t is never delivered.
4. Redirect to 0xFFE, stall=0 → instr_pc 0xFFE, 0xFFF, 0x000, 0x001; address_imem wraps 0xFFF→0x000.
5. redirect=1 and stall=1 in the same cycle with skid full → next cycle instr_valid=0, skid empty, address_imem=redirect_target.
6. reset=1 during a stall with skid full → next cycle address_imem=RESET_PC, instr_valid=0, instr=0, instr_pc=0; fetch restarts per scenario 1.
